// File: rtl/key_pkg.sv
// Shared defaults and helpers for the multi-channel key debouncer.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package key_pkg;

  localparam int KEY_DEB_DEFAULT  = 20000;
  localparam int KEY_LONG_DEFAULT = 1000000;
  localparam int KEY_SYNC_DEFAULT = 2;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int key_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: synchroniser, restarting stability counter, press/release pulses, optional long-press.
// Latency: clean edge on key -> key_state/pulse SYNC_STAGES+DEB_CYCLES cycles later; key_long LONG_CYCLES after press.
// Backpressure: none; pulses are fire-and-forget, 1 cycle wide.
// Ports: clk, rst (sync, active-high), key (async raw pin, 1 = pressed),
//        key_state (debounced level), key_press / key_release / key_long (1-cycle pulses).
// Macro KEY_LONG_PRESS_EN enables the hold counter; without it key_long is constant 0.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CYCLES  = KEY_DEB_DEFAULT,
  parameter int SYNC_STAGES = KEY_SYNC_DEFAULT,
  parameter int LONG_CYCLES = KEY_LONG_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int              CW       = key_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("key_debounce_ch: DEB_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_debounce_ch: SYNC_STAGES must be >= 2");
  end
  if (LONG_CYCLES <= DEB_CYCLES) begin : g_bad_long
    $error("key_debounce_ch: LONG_CYCLES must exceed DEB_CYCLES");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   ksync;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], key};
    ksync     = sync_q[SYNC_STAGES-1];
    cnt_d     = cnt_q;
    state_d   = state_q;
    // Any sample matching the current level restarts the window, so only
    // DEB_CYCLES consecutive disagreeing samples can flip the level.
    if (ksync == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = ksync;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Pulses are registered alongside state so they line up with key_state.
    press_d   = state_d & ~state_q;
    release_d = ~state_d & state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int            HW       = key_cnt_w(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  always_comb begin
    hold_d = hold_q;
    // Counts cycles spent pressed; saturates so only one pulse per press.
    if (!state_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end
    long_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: replicates key_debounce_ch per key pin.
// Latency: SYNC_STAGES+DEB_CYCLES cycles from a clean pin edge to key_state/press/release.
// Backpressure: none; outputs are level plus 1-cycle pulses.
// Ports: clk, rst (sync, active-high), key[N_KEYS] raw pins;
//        key_state, key_press, key_release, key_long [N_KEYS] per-channel outputs.
// Macro KEY_LONG_PRESS_EN enables key_long; otherwise key_long is all zeros.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int DEB_CYCLES  = KEY_DEB_DEFAULT,
  parameter int SYNC_STAGES = KEY_SYNC_DEFAULT,
  parameter int LONG_CYCLES = KEY_LONG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES  (DEB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key         (key[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Testbench for key_debounce_multi: directed scenarios plus random key activity against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_debounce_multi;

  localparam int N    = 4;
  localparam int DEB  = 8;
  localparam int SYNC = 2;
  localparam int LONG = 32;
  localparam int LAT  = SYNC + DEB;

`ifdef KEY_LONG_PRESS_EN
  localparam logic LONG_ON = 1'b1;
`else
  localparam logic LONG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key = '0;
  logic [N-1:0] key_state, key_press, key_release, key_long;

  key_debounce_multi #(
    .N_KEYS      (N),
    .DEB_CYCLES  (DEB),
    .SYNC_STAGES (SYNC),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int long_cnt = 0;
  int press_cnt1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the pin as seen after SYNC clocks, and the run of
  // samples disagreeing with the accepted level since it last changed.
  bit           m_pipe  [N][$];
  bit           m_state [N];
  bit           m_since [N][$];
  int           m_held  [N];
  logic [N-1:0] e_state, e_press, e_release, e_long;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pipe[i] = {};
      for (int s = 0; s < SYNC; s++) m_pipe[i].push_back(1'b0);
      m_state[i] = 1'b0;
      m_since[i] = {};
      m_held[i]  = 0;
    end
    e_state   = '0;
    e_press   = '0;
    e_release = '0;
    e_long    = '0;
  endfunction

  function automatic void model_edge();
    bit seen;
    for (int i = 0; i < N; i++) begin
      seen = m_pipe[i].pop_front();
      m_pipe[i].push_back(key[i]);
      e_press[i]   = 1'b0;
      e_release[i] = 1'b0;
      e_long[i]    = 1'b0;
      // Cycles spent pressed since the press pulse; fires once at LONG.
      if (m_state[i]) begin
        if (m_held[i] < LONG) begin
          m_held[i]++;
          if (m_held[i] == LONG) e_long[i] = LONG_ON;
        end
      end else begin
        m_held[i] = 0;
      end
      if (seen == m_state[i]) begin
        m_since[i] = {};
      end else begin
        m_since[i].push_back(seen);
        if (m_since[i].size() == DEB) begin
          m_state[i]   = seen;
          e_press[i]   = seen;
          e_release[i] = !seen;
          m_since[i]   = {};
        end
      end
      e_state[i] = m_state[i];
    end
  endfunction

  // One clock: advance the model at the edge, compare every output at negedge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    chk("outs", {key_state, key_press, key_release, key_long},
                {e_state, e_press, e_release, e_long});
    long_cnt   += $countones(key_long);
    press_cnt1 += int'(key_press[1]);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int dur [N];

  initial begin
    model_reset();
    rst = 1'b1;
    key = '0;
    steps(2);
    chk("reset_state", {key_state, key_press, key_release, key_long}, 16'h0);

    // 1. Clean press on channel 0, then 6. long press while held.
    rst = 1'b0;
    steps(8);
    key[0] = 1'b1;
    steps(LAT - 1);
    chk("t1_early", key_press, 4'b0000);
    step();
    chk("t1_press", key_press, 4'b0001);
    chk("t1_state", key_state, 4'b0001);
    long_cnt = 0;
    steps(LONG - 1);
    chk("t6_early", key_long, 4'b0000);
    step();
    chk("t6_long", key_long, {3'b000, LONG_ON});
    steps(60 - LONG);
    chk("t6_once", long_cnt, LONG_ON ? 1 : 0);

    // 3. Release.
    key[0] = 1'b0;
    steps(LAT - 1);
    chk("t3_early", key_release, 4'b0000);
    step();
    chk("t3_release", key_release, 4'b0001);
    chk("t3_state", key_state, 4'b0000);
    steps(3);

    // 2. Bounce on channel 1: 3-cycle segments, last one low, then a clean rise.
    press_cnt1 = 0;
    for (int c = 0; c < 30; c++) begin
      key[1] = ((c / 3) % 2) == 0;
      step();
    end
    chk("t2_no_pulse", press_cnt1, 0);
    key[1] = 1'b1;
    steps(LAT - 1);
    chk("t2_early", key_press, 4'b0000);
    step();
    chk("t2_press", key_press, 4'b0010);
    key[1] = 1'b0;
    steps(LAT + 2);

    // 4. Simultaneous press on all channels.
    key = 4'b1111;
    steps(LAT - 1);
    chk("t4_early", key_press, 4'b0000);
    step();
    chk("t4_press", key_press, 4'b1111);
    key = '0;
    steps(LAT + 2);
    chk("t4_state", key_state, 4'b0000);

    // 5. Reset while channel 2 is mid-debounce, key held through reset.
    key[2] = 1'b1;
    steps(SYNC + 5);
    rst = 1'b1;
    step();
    chk("t5_in_reset", {key_state, key_press, key_release, key_long}, 16'h0);
    step();
    rst = 1'b0;
    steps(LAT - 1);
    chk("t5_early", key_press, 4'b0000);
    step();
    chk("t5_press", key_press, 4'b0100);
    key[2] = 1'b0;
    steps(LAT + 2);

    // Random activity: each pin holds a level for a random time, occasional reset.
    for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 45);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          key[i] = ~key[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 50);
        end
      end
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
